// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-control encodings: hazard codes, FSM states, PC source selects and stage IDs.
package hazard_ctrl_pkg;

  typedef enum logic [3:0] {
    HZ_NONE      = 4'd0,
    STALL_MMU    = 4'd1,
    STALL_EARLY  = 4'd2,
    FLUSH_EARLY  = 4'd3,
    FLUSH_ALL    = 4'd4,
    FLUSH_EXCEPT = 4'd5
  } hazard_e;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MMU_WAIT   = 2'd1,
    ST_TRAP_DRAIN = 2'd2,
    ST_SERIALIZE  = 2'd3
  } hz_state_e;

  typedef enum logic [1:0] {
    PC_SEQ       = 2'd0,
    PC_EX_TARGET = 2'd1,
    PC_TRAP_VEC  = 2'd2,
    PC_MEM_NEXT  = 2'd3
  } pc_sel_e;

  localparam int unsigned STAGE_IF  = 0;
  localparam int unsigned STAGE_ID  = 1;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 3;
  localparam int unsigned STAGE_WB  = 4;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: requests a one-cycle ID stall when ID reads the register a load in EX writes.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  output logic              stall_o
);

  logic hit_rs1, hit_rs2;

  assign hit_rs1 = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign hit_rs2 = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign stall_o = ex_is_load_i && (ex_rd_i != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard sequencer: priority arbitration plus MMU-walk / trap-drain / serialize holding.
// Optional perf counters are compiled in with `define HAZARD_PERF_EN.
//   state         | meaning
//   ST_RUN        | normal issue, per-cycle priority arbitration
//   ST_MMU_WAIT   | page walk in flight, pipeline and PC stalled
//   ST_TRAP_DRAIN | holding FLUSH_EXCEPT after a trap/mret
//   ST_SERIALIZE  | one PC-hold cycle after fence.i / satp write
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TRAP_DRAIN = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_serialize,
  input  logic              mmu_req,
  input  logic              mmu_done,
  input  logic              wb_trap,
  output logic [3:0]        hazard_signal,
  output logic              pc_hold,
  output logic [1:0]        pc_sel,
  output logic              mmu_abort,
  output logic [1:0]        state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
  output logic [CNT_W-1:0]  perf_mmu_cnt
`endif
);

  localparam int DW = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(TRAP_DRAIN - 1);

  hz_state_e     state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  hazard_e       hz;
  pc_sel_e       sel;
  logic          hold, abort, load_use;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use (
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ex_is_load_i (ex_is_load),
    .ex_rd_i      (ex_rd),
    .stall_o      (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hz      = HZ_NONE;
    sel     = PC_SEQ;
    hold    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      ST_RUN, ST_SERIALIZE, ST_MMU_WAIT: begin
        if (wb_trap) begin
          hz    = FLUSH_EXCEPT;
          sel   = PC_TRAP_VEC;
          abort = (state_q == ST_MMU_WAIT);
          if (TRAP_DRAIN > 1) begin
            state_d = ST_TRAP_DRAIN;
            cnt_d   = DRAIN_LOAD;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end else if (state_q == ST_MMU_WAIT) begin
          hz   = STALL_MMU;
          hold = 1'b1;
          if (mmu_done) state_d = ST_RUN;
        end else if (state_q == ST_SERIALIZE) begin
          hold    = 1'b1;
          state_d = ST_RUN;
        end else if (mmu_req) begin
          hz      = STALL_MMU;
          hold    = 1'b1;
          state_d = ST_MMU_WAIT;
        end else if (mem_serialize) begin
          hz      = FLUSH_ALL;
          sel     = PC_MEM_NEXT;
          state_d = ST_SERIALIZE;
        end else if (ex_redirect) begin
          // the ID instruction is squashed, so any load-use stall is moot
          hz  = FLUSH_EARLY;
          sel = PC_EX_TARGET;
        end else if (load_use) begin
          hz   = STALL_EARLY;
          hold = 1'b1;
        end
      end
      ST_TRAP_DRAIN: begin
        // PC was already redirected on entry; a repeat trap only extends the drain
        hz = FLUSH_EXCEPT;
        if (wb_trap) begin
          cnt_d = DRAIN_LOAD;
        end else if (cnt_q <= DW'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      hz    = HZ_NONE;
      sel   = PC_SEQ;
      hold  = 1'b0;
      abort = 1'b0;
    end
  end

  assign hazard_signal = hz;
  assign pc_sel        = sel;
  assign pc_hold       = hold;
  assign mmu_abort     = abort;
  assign state_o       = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q, mmu_q;
  logic             is_stall, is_flush, mmu_entry;

  assign is_stall  = (hz == STALL_EARLY) || (hz == STALL_MMU);
  assign is_flush  = (hz == FLUSH_EARLY) || (hz == FLUSH_ALL) || (hz == FLUSH_EXCEPT);
  assign mmu_entry = (state_q != ST_MMU_WAIT) && (state_d == ST_MMU_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      mmu_q   <= '0;
    end else begin
      if (is_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (is_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
      if (mmu_entry && (mmu_q != '1))  mmu_q   <= mmu_q + CNT_W'(1);
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
  assign perf_mmu_cnt   = mmu_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_ctrl;

  localparam int TD    = 2;
  localparam int AW    = 5;
  localparam int CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_use_rs1, id_use_rs2, ex_is_load;
  logic          ex_redirect, mem_serialize, mmu_req, mmu_done, wb_trap;
  wire  [3:0]    hazard_signal;
  wire           pc_hold, mmu_abort;
  wire  [1:0]    pc_sel, state_o;
`ifdef HAZARD_PERF_EN
  wire  [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_mmu_cnt;
`endif

  hazard_ctrl #(.TRAP_DRAIN(TD), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_is_load    (ex_is_load),
    .ex_rd         (ex_rd),
    .ex_redirect   (ex_redirect),
    .mem_serialize (mem_serialize),
    .mmu_req       (mmu_req),
    .mmu_done      (mmu_done),
    .wb_trap       (wb_trap),
    .hazard_signal (hazard_signal),
    .pc_hold       (pc_hold),
    .pc_sel        (pc_sel),
    .mmu_abort     (mmu_abort),
    .state_o       (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_mmu_cnt  (perf_mmu_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: walking / serialize-hold flags and remaining FLUSH_EXCEPT drain cycles
  bit   m_walk, m_ser, nx_walk, nx_ser;
  int   m_left, nx_left;
  logic [9:0] exp_vec;
  wire  [9:0] obs = {hazard_signal, pc_hold, pc_sel, mmu_abort, state_o};

  task automatic model_eval();
    logic [3:0] hz;
    logic       hold, ab;
    logic [1:0] sel, st;
    bit         lu;
    hz = 4'd0; hold = 1'b0; sel = 2'd0; ab = 1'b0;
    st = (m_left > 0) ? 2'd2 : (m_walk ? 2'd1 : (m_ser ? 2'd3 : 2'd0));
    nx_walk = m_walk; nx_ser = m_ser; nx_left = m_left;
    lu = ex_is_load && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (rst) begin
      nx_walk = 0; nx_ser = 0; nx_left = 0;
    end else if (m_left > 0) begin
      hz = 4'd5;
      nx_left = wb_trap ? TD - 1 : m_left - 1;
    end else if (m_walk && wb_trap) begin
      hz = 4'd5; sel = 2'd2; ab = 1'b1; nx_walk = 0; nx_left = TD - 1;
    end else if (m_walk) begin
      hz = 4'd1; hold = 1'b1;
      if (mmu_done) nx_walk = 0;
    end else if (wb_trap) begin
      hz = 4'd5; sel = 2'd2; nx_ser = 0; nx_left = TD - 1;
    end else if (m_ser) begin
      hold = 1'b1; nx_ser = 0;
    end else if (mmu_req) begin
      hz = 4'd1; hold = 1'b1; nx_walk = 1;
    end else if (mem_serialize) begin
      hz = 4'd4; sel = 2'd3; nx_ser = 1;
    end else if (ex_redirect) begin
      hz = 4'd3; sel = 2'd1;
    end else if (lu) begin
      hz = 4'd2; hold = 1'b1;
    end
    exp_vec = {hz, hold, sel, ab, st};
  endtask

  task automatic advance();
    @(posedge clk);
    m_walk = nx_walk; m_ser = nx_ser; m_left = nx_left;
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    ex_redirect = 0; mem_serialize = 0; mmu_req = 0; mmu_done = 0; wb_trap = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) rst = 1'b0;
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL reset[%0d]: got %03h expected %03h", i, obs, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_load_use();
    for (int pass = 0; pass < 2; pass++) begin
      clear_inputs();
      ex_is_load = 1; ex_rd = (pass == 0) ? 5'd5 : 5'd0; id_rs2 = ex_rd; id_use_rs2 = 1;
      @(negedge clk); model_eval();
      n_checks++;
      if (hazard_signal !== ((pass == 0) ? 4'd2 : 4'd0) || pc_hold !== (pass == 0))
        $display("FAIL load_use[%0d]: got hz=%0d hold=%0b", pass, hazard_signal, pc_hold);
      else n_pass++;
      n_checks++;
      if (obs !== exp_vec) $display("FAIL load_use_model[%0d]: got %03h expected %03h", pass, obs, exp_vec);
      else n_pass++;
      advance();
      clear_inputs();
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL load_use_after[%0d]: got %03h expected %03h", pass, obs, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_redirect_vs_load_use();
    clear_inputs();
    ex_is_load = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1; ex_redirect = 1;
    @(negedge clk); model_eval();
    n_checks++;
    if (hazard_signal !== 4'd3 || pc_sel !== 2'd1 || pc_hold !== 1'b0)
      $display("FAIL redirect_vs_lu: got hz=%0d sel=%0d hold=%0b", hazard_signal, pc_sel, pc_hold);
    else n_pass++;
    advance();
    clear_inputs();
  endtask

  task automatic test_mmu_walk();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      mmu_req  = (c == 0);
      mmu_done = (c == 4);
      ex_is_load = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL mmu_walk[%0d]: got %03h expected %03h", c, obs, exp_vec);
      else n_pass++;
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_trap_abort_walk();
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      mmu_req  = (c == 0);
      wb_trap  = (c == 2);
      mmu_done = (c == 2);
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL trap_abort[%0d]: got %03h expected %03h", c, obs, exp_vec);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (mmu_abort !== 1'b1 || hazard_signal !== 4'd5)
          $display("FAIL trap_abort_pulse: got abort=%0b hz=%0d", mmu_abort, hazard_signal);
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_serialize();
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      mem_serialize = (c == 0) || (c == 3);
      wb_trap       = (c == 4);
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL serialize[%0d]: got %03h expected %03h", c, obs, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      wb_trap = (c == 0);
      rst     = (c == 1);
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) $display("FAIL reset_drain[%0d]: got %03h expected %03h", c, obs, exp_vec);
      else n_pass++;
      advance();
    end
    rst = 1'b0;
`ifdef HAZARD_PERF_EN
    clear_inputs();
    rst = 1'b1; advance(); rst = 1'b0;
    m_walk = 0; m_ser = 0; m_left = 0;
    n_checks++;
    if (perf_stall_cnt !== '0 || perf_flush_cnt !== '0 || perf_mmu_cnt !== '0)
      $display("FAIL perf_reset: got %0d %0d %0d", perf_stall_cnt, perf_flush_cnt, perf_mmu_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      rst           = ($urandom_range(0, 59) == 0);
      wb_trap       = ($urandom_range(0, 15) == 0);
      mmu_req       = ($urandom_range(0, 9) == 0);
      mmu_done      = ($urandom_range(0, 3) == 0);
      mem_serialize = ($urandom_range(0, 9) == 0);
      ex_redirect   = ($urandom_range(0, 5) == 0);
      ex_is_load    = $urandom_range(0, 1);
      ex_rd         = AW'($urandom_range(0, 3));
      id_rs1        = AW'($urandom_range(0, 3));
      id_rs2        = AW'($urandom_range(0, 3));
      id_use_rs1    = $urandom_range(0, 1);
      id_use_rs2    = $urandom_range(0, 1);
      @(negedge clk); model_eval();
      n_checks++;
      if (obs !== exp_vec) begin
        errs++;
        if (errs <= 10) $display("FAIL random[%0d]: got %03h expected %03h", c, obs, exp_vec);
      end else n_pass++;
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_walk = 0; m_ser = 0; m_left = 0;
    rst = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_redirect_vs_load_use();
    test_mmu_walk();
    test_trap_abort_walk();
    test_serialize();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
